vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port arbiter for the 16 KB CGA video RAM, running in the 25 MHz pixel domain. It shares one read/write RAM port between the display fetch path (CRTC character/pixel reads) and CPU byte reads/writes. Display fetches have priority. A starvation counter guarantees CPU progress. The block sits between the CRTC address generator, the CPU-side bus bridge and the VRAM macro, replacing the dual-clock write port with a single scheduled port.

## Interface
- STARVE_MAX, 4: consecutive display wins tolerated while a CPU request waits; legal range 1..15.
- iClk25  in  1  pixel clock; all logic on rising edge
- iRstN  in  1  asynchronous active-low reset
- iDispReq  in  1  one-cycle fetch strobe from CRTC
- iDispAddr  in  13  word address of fetch
- oDispValid  out  1  one-cycle strobe, oDispData valid
- oDispData  out  16  fetched word ({char, attr} or 8 gfx pixels)
- iCpuReq  in  1  CPU request; held with fields stable until oCpuAck
- iCpuWr  in  1  1 = write, 0 = read
- iCpuAddr  in  14  byte address; bit 0 = 0 selects [15:8], 1 selects [7:0]
- iCpuWrData  in  8  write byte
- oCpuAck  out  1  one-cycle completion strobe
- oCpuRdData  out  8  read byte, valid with oCpuAck
- oRamAddr  out  13  RAM word address (registered)
- oRamWe  out  1  RAM write enable (registered)
- oRamBe  out  2  byte enables {hi, lo} (registered)
- oRamWrData  out  16  write byte replicated on both lanes (registered)
- iRamRdData  in  16  RAM read data; one-clock synchronous latency

## Operation
- Each edge issues at most one RAM access. Priority order:
  1. starvation override (CPU)
  2. pending display
  3. new iDispReq
  4. CPU
  5. idle (oRamWe = 0, oRamBe = 0, address held)
- Display pending register (1 entry): if iDispReq is sampled on an edge where the CPU wins, its address is stored. The stored request is served before any new display request. A new iDispReq arriving while pending is served is moved into pending. Display requests are never dropped; they are returned in order.
- Starvation counter (4 bit): increments on each edge where a CPU request is eligible but display wins. When it equals STARVE_MAX, the CPU wins and the counter clears. It also clears when the CPU issues or when no CPU request is eligible.
- CPU eligibility: iCpuReq = 1, no CPU read in flight, and oCpuAck not high this cycle, so the same request is not served twice.
- CPU read: issue word read, capture iRamRdData, return the byte selected by iCpuAddr[0].
- CPU write: oRamBe = 2'b10 if addr[0] = 0, 2'b01 otherwise; oRamWrData = {byte, byte}.
- Read-return tag pipeline (2 stages: none/disp/cpu) routes captured data.
- Reset values: all outputs 0, pending empty, counter 0, tags none. Reset asserted mid-access discards in-flight reads; no strobe is produced.

## Timing
- Display: iDispReq sampled at edge E0 and issued → RAM samples at E1 → captured at E2. oDispValid is high for the cycle after E2 (latency 2 edges). Each pending deferral adds 1 edge.
- CPU write: issued at E0; oCpuAck high the cycle after E0.
- CPU read: issued at E0; oCpuAck and oCpuRdData valid the cycle after E2. No other CPU access is issued until ack.
- Simultaneous display return and CPU return cannot occur on the same edge (one issue per edge).
- With iDispReq every cycle, the CPU is served every STARVE_MAX+1 edges.

## Configuration
- VRAM_ARB_POSTWR_EN defined: 1-entry posted write buffer.
  - CPU write is acked the cycle after sampling and stored in the buffer.
  - The buffer drains at CPU priority, including the starvation override.
  - A new CPU request is not eligible while the buffer is full.
- VRAM_ARB_POSTWR_EN undefined: writes ack only on issue, as above; no buffer.

## Test plan
- Display only: iDispReq at addr 0x0010, RAM word 0x4107 → oDispValid 2 edges later, oDispData 0x4107; CPU idle, counter stays 0.
- CPU byte write addr 0x0021 data 0x5A, no display → oRamAddr 0x0010, oRamBe 01, oRamWrData 0x5A5A, oCpuAck the next cycle; then read 0x0021 → oCpuRdData 0x5A.
- Collision: iDispReq and CPU read on the same edge → display issued first, CPU issued the next edge, acked 3 edges after the collision.
- Starvation: iDispReq every cycle (addrs 0,1,2,…), CPU write pending, STARVE_MAX = 4 → CPU issues on the 5th edge; display data is returned in address order with no gaps lost.
- Reset pulse (iRstN low 1 cycle) one edge after a CPU read issue → no oCpuAck, all outputs 0, next request served normally.
- With VRAM_ARB_POSTWR_EN: two back-to-back writes under a continuous display stream → first acked the next cycle, second acked only after the first drains.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port scheduler for the 16 KB CGA video RAM in the 25 MHz pixel domain.
// Define VRAM_ARB_POSTWR_EN to add a 1-entry posted CPU write buffer.
module vram_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        iClk25,
    input  logic        iRstN,
    input  logic        iDispReq,
    input  logic [12:0] iDispAddr,
    output logic        oDispValid,
    output logic [15:0] oDispData,
    input  logic        iCpuReq,
    input  logic        iCpuWr,
    input  logic [13:0] iCpuAddr,
    input  logic [7:0]  iCpuWrData,
    output logic        oCpuAck,
    output logic [7:0]  oCpuRdData,
    output logic [12:0] oRamAddr,
    output logic        oRamWe,
    output logic [1:0]  oRamBe,
    output logic [15:0] oRamWrData,
    input  logic [15:0] iRamRdData
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2
    } tag_e;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_PEND = 2'd2,
        GNT_NEW  = 2'd3
    } grant_e;

    tag_e        tag0_r;
    tag_e        tag1_r;
    logic        dispPendValid_r;
    logic [12:0] dispPendAddr_r;
    logic [3:0]  starveCnt_r;
    logic        cpuRdBusy_r;
    logic        cpuByteSel_r;

    logic        cpuElig_s;
    logic        cpuWant_s;
    logic        cpuIsWr_s;
    logic [13:0] cpuAddr_s;
    logic [7:0]  cpuData_s;
    logic        wbAccept_s;
    logic        wrAckOnIssue_s;
    logic        contend_s;
    grant_e      grant_s;

`ifdef VRAM_ARB_POSTWR_EN
    logic        wbValid_r;
    logic [13:0] wbAddr_r;
    logic [7:0]  wbData_r;

    // CPU source select: a buffered write drains ahead of any new request
    always_comb begin
        cpuElig_s      = iCpuReq && !cpuRdBusy_r && !oCpuAck && !wbValid_r;
        wbAccept_s     = cpuElig_s && iCpuWr;
        wrAckOnIssue_s = 1'b0;
        if (wbValid_r) begin
            cpuWant_s = 1'b1;
            cpuIsWr_s = 1'b1;
            cpuAddr_s = wbAddr_r;
            cpuData_s = wbData_r;
        end else begin
            cpuWant_s = cpuElig_s && !iCpuWr;
            cpuIsWr_s = 1'b0;
            cpuAddr_s = iCpuAddr;
            cpuData_s = iCpuWrData;
        end
    end

    // Posted write buffer: filled on acceptance, emptied when its write issues
    always_ff @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) begin
            wbValid_r <= 1'b0;
            wbAddr_r  <= 14'd0;
            wbData_r  <= 8'd0;
        end else if (wbAccept_s) begin
            wbValid_r <= 1'b1;
            wbAddr_r  <= iCpuAddr;
            wbData_r  <= iCpuWrData;
        end else if ((grant_s == GNT_CPU) && cpuIsWr_s) begin
            wbValid_r <= 1'b0;
        end
    end
`else
    // CPU source select: the live request goes straight to the port
    always_comb begin
        cpuElig_s      = iCpuReq && !cpuRdBusy_r && !oCpuAck;
        wbAccept_s     = 1'b0;
        wrAckOnIssue_s = 1'b1;
        cpuWant_s      = cpuElig_s;
        cpuIsWr_s      = iCpuWr;
        cpuAddr_s      = iCpuAddr;
        cpuData_s      = iCpuWrData;
    end
`endif

    // Port grant; the starvation override is held off only when it would leave
    // a new display request with nowhere to go (pending slot already occupied)
    always_comb begin
        contend_s = cpuWant_s || cpuElig_s;
        if (cpuWant_s && (starveCnt_r == STARVE_LIM) && !(dispPendValid_r && iDispReq)) begin
            grant_s = GNT_CPU;
        end else if (dispPendValid_r) begin
            grant_s = GNT_PEND;
        end else if (iDispReq) begin
            grant_s = GNT_NEW;
        end else if (cpuWant_s) begin
            grant_s = GNT_CPU;
        end else begin
            grant_s = GNT_IDLE;
        end
    end

    // Issue, display pending slot, starvation counter and read-return pipeline
    always_ff @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) begin
            oDispValid      <= 1'b0;
            oDispData       <= 16'd0;
            oCpuAck         <= 1'b0;
            oCpuRdData      <= 8'd0;
            oRamAddr        <= 13'd0;
            oRamWe          <= 1'b0;
            oRamBe          <= 2'b00;
            oRamWrData      <= 16'd0;
            dispPendValid_r <= 1'b0;
            dispPendAddr_r  <= 13'd0;
            starveCnt_r     <= 4'd0;
            tag0_r          <= TAG_NONE;
            tag1_r          <= TAG_NONE;
            cpuRdBusy_r     <= 1'b0;
            cpuByteSel_r    <= 1'b0;
        end else begin
            tag1_r     <= tag0_r;
            oDispValid <= 1'b0;
            oCpuAck    <= wbAccept_s;

            case (grant_s)
                GNT_CPU: begin
                    oRamAddr <= cpuAddr_s[13:1];
                    if (cpuIsWr_s) begin
                        oRamWe     <= 1'b1;
                        oRamBe     <= cpuAddr_s[0] ? 2'b01 : 2'b10;
                        oRamWrData <= {cpuData_s, cpuData_s};
                        tag0_r     <= TAG_NONE;
                        oCpuAck    <= wrAckOnIssue_s;
                    end else begin
                        oRamWe       <= 1'b0;
                        oRamBe       <= 2'b00;
                        tag0_r       <= TAG_CPU;
                        cpuRdBusy_r  <= 1'b1;
                        cpuByteSel_r <= cpuAddr_s[0];
                    end
                    if (iDispReq) begin
                        dispPendValid_r <= 1'b1;
                        dispPendAddr_r  <= iDispAddr;
                    end
                end
                GNT_PEND: begin
                    oRamAddr        <= dispPendAddr_r;
                    oRamWe          <= 1'b0;
                    oRamBe          <= 2'b00;
                    tag0_r          <= TAG_DISP;
                    dispPendValid_r <= iDispReq;
                    if (iDispReq) begin
                        dispPendAddr_r <= iDispAddr;
                    end
                end
                GNT_NEW: begin
                    oRamAddr <= iDispAddr;
                    oRamWe   <= 1'b0;
                    oRamBe   <= 2'b00;
                    tag0_r   <= TAG_DISP;
                end
                default: begin
                    oRamWe <= 1'b0;
                    oRamBe <= 2'b00;
                    tag0_r <= TAG_NONE;
                end
            endcase

            if (!contend_s || (grant_s == GNT_CPU)) begin
                starveCnt_r <= 4'd0;
            end else if (starveCnt_r != STARVE_LIM) begin
                starveCnt_r <= starveCnt_r + 4'd1;
            end

            // Data sampled now belongs to the access issued two edges ago
            if (tag1_r == TAG_DISP) begin
                oDispValid <= 1'b1;
                oDispData  <= iRamRdData;
            end else if (tag1_r == TAG_CPU) begin
                oCpuAck     <= 1'b1;
                oCpuRdData  <= cpuByteSel_r ? iRamRdData[7:0] : iRamRdData[15:8];
                cpuRdBusy_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a word RAM model and a
// byte-level reference memory; directed timing cases followed by random traffic.
module tb_vram_arbiter;
    localparam int STARVE_MAX = 4;

    logic        iClk25 = 1'b0;
    logic        iRstN = 1'b0;
    logic        iDispReq = 1'b0;
    logic [12:0] iDispAddr = 13'd0;
    logic        oDispValid;
    logic [15:0] oDispData;
    logic        iCpuReq = 1'b0;
    logic        iCpuWr = 1'b0;
    logic [13:0] iCpuAddr = 14'd0;
    logic [7:0]  iCpuWrData = 8'd0;
    logic        oCpuAck;
    logic [7:0]  oCpuRdData;
    logic [12:0] oRamAddr;
    logic        oRamWe;
    logic [1:0]  oRamBe;
    logic [15:0] oRamWrData;
    logic [15:0] iRamRdData = 16'd0;

    typedef struct {
        bit         isRd;
        logic [7:0] data;
    } cpuExp_t;

    logic [15:0] ram    [0:8191];
    logic [15:0] refMem [0:8191];
    logic [15:0] dispQ[$];
    cpuExp_t     cpuQ[$];
    int          nCompared = 0;
    int          nMismatch = 0;
    int          cyc = 0;

    vram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .iClk25(iClk25), .iRstN(iRstN),
        .iDispReq(iDispReq), .iDispAddr(iDispAddr),
        .oDispValid(oDispValid), .oDispData(oDispData),
        .iCpuReq(iCpuReq), .iCpuWr(iCpuWr), .iCpuAddr(iCpuAddr), .iCpuWrData(iCpuWrData),
        .oCpuAck(oCpuAck), .oCpuRdData(oCpuRdData),
        .oRamAddr(oRamAddr), .oRamWe(oRamWe), .oRamBe(oRamBe), .oRamWrData(oRamWrData),
        .iRamRdData(iRamRdData)
    );

    always #20 iClk25 = ~iClk25;

    // Synchronous single-port RAM with byte enables and one clock of read latency
    always @(posedge iClk25) begin
        iRamRdData <= ram[oRamAddr];
        if (oRamWe && oRamBe[1]) ram[oRamAddr][15:8] <= oRamWrData[15:8];
        if (oRamWe && oRamBe[0]) ram[oRamAddr][7:0]  <= oRamWrData[7:0];
    end

    initial forever begin
        @(posedge iClk25);
        cyc++;
    end

    function automatic logic [15:0] initWord(input int i);
        return 16'(i * 40503 + 7) ^ 16'h3C3C;
    endfunction

    function automatic logic [7:0] refReadByte(input logic [13:0] a);
        logic [15:0] w;
        w = refMem[a[13:1]];
        return a[0] ? w[7:0] : w[15:8];
    endfunction

    task automatic refWriteByte(input logic [13:0] a, input logic [7:0] d);
        if (a[0]) refMem[a[13:1]][7:0] = d;
        else      refMem[a[13:1]][15:8] = d;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic dispDrive(input logic [12:0] a);
        iDispReq  = 1'b1;
        iDispAddr = a;
        dispQ.push_back(refMem[a]);
    endtask

    task automatic cpuStart(input logic wr, input logic [13:0] a, input logic [7:0] d, input bit track);
        cpuExp_t e;
        iCpuReq    = 1'b1;
        iCpuWr     = wr;
        iCpuAddr   = a;
        iCpuWrData = d;
        if (track) begin
            e.isRd = !wr;
            if (wr) begin
                refWriteByte(a, d);
                e.data = 8'h00;
            end else begin
                e.data = refReadByte(a);
            end
            cpuQ.push_back(e);
        end
    endtask

    task automatic waitAck(input string name, output int ackCyc);
        int startCyc;
        startCyc = cyc;
        ackCyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge iClk25);
            if (oCpuAck) begin
                ackCyc = cyc;
                break;
            end
        end
        iCpuReq = 1'b0;
        check(name, 32'((ackCyc != -1) && (ackCyc - startCyc <= 64)), 32'd1);
    endtask

    // Scoreboard monitor: every returned display word and CPU ack is matched in order
    initial forever begin
        cpuExp_t e;
        @(negedge iClk25);
        if (oDispValid) begin
            if (dispQ.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("FAIL disp_unexpected: actual strobe data 0x%0h required no strobe", oDispData);
            end else begin
                check("disp_data", 32'(oDispData), 32'(dispQ.pop_front()));
            end
        end
        if (oCpuAck) begin
            if (cpuQ.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("FAIL cpu_ack_unexpected: actual ack required none");
            end else begin
                e = cpuQ.pop_front();
                if (e.isRd) check("cpu_rd_data", 32'(oCpuRdData), 32'(e.data));
            end
        end
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: actual no finish required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, ackC, weC, dvC, a1, a2, dr, cnt;
        logic [12:0] firstAddr, secondAddr, weAddr;
        logic [1:0]  weBe;
        logic [15:0] weData;

        for (int i = 0; i < 8192; i++) begin
            ram[i]    = initWord(i);
            refMem[i] = initWord(i);
        end
        ram[16'h10]    = 16'h4107;
        refMem[16'h10] = 16'h4107;

        repeat (3) @(negedge iClk25);
        check("reset_disp_cpu", 32'({oDispValid, oDispData, oCpuAck, oCpuRdData}), 32'd0);
        check("reset_ram", 32'({oRamAddr, oRamWe, oRamBe, oRamWrData}), 32'd0);
        iRstN = 1'b1;
        repeat (2) @(negedge iClk25);

        // Display only
        c = cyc;
        dispDrive(13'h0010);
        dvC = -1;
        for (int k = 0; k < 10 && dvC == -1; k++) begin
            @(negedge iClk25);
            iDispReq = 1'b0;
            if (oDispValid) dvC = cyc;
        end
        check("disp_latency_edges", 32'(dvC - (c + 1)), 32'd2);
        repeat (3) @(negedge iClk25);

        // CPU byte write then read back
        c = cyc;
        cpuStart(1'b1, 14'h0021, 8'h5A, 1'b1);
        ackC = -1;
        weC = -1;
        for (int k = 0; k < 10 && (ackC == -1 || weC == -1); k++) begin
            @(negedge iClk25);
            if (oRamWe && weC == -1) begin
                weC = cyc; weAddr = oRamAddr; weBe = oRamBe; weData = oRamWrData;
            end
            if (oCpuAck && ackC == -1) begin
                ackC = cyc;
                iCpuReq = 1'b0;
            end
        end
        check("wr_ack_latency", 32'(ackC - c), 32'd1);
        check("wr_ram_addr", 32'(weAddr), 32'h0010);
        check("wr_ram_be", 32'(weBe), 32'h1);
        check("wr_ram_data", 32'(weData), 32'h5A5A);
        @(negedge iClk25);
        c = cyc;
        cpuStart(1'b0, 14'h0021, 8'h00, 1'b1);
        waitAck("cpu_ack_within_bound", ackC);
        check("rd_ack_latency", 32'(ackC - c), 32'd3);
        repeat (3) @(negedge iClk25);

        // Collision: display and CPU read sampled on the same edge
        c = cyc;
        dispDrive(13'h0020);
        cpuStart(1'b0, 14'h0101, 8'h00, 1'b1);
        dvC = -1;
        ackC = -1;
        for (int k = 1; k <= 12 && (dvC == -1 || ackC == -1); k++) begin
            @(negedge iClk25);
            iDispReq = 1'b0;
            if (k == 1) firstAddr = oRamAddr;
            if (k == 2) secondAddr = oRamAddr;
            if (oDispValid) dvC = cyc;
            if (oCpuAck && ackC == -1) begin
                ackC = cyc;
                iCpuReq = 1'b0;
            end
        end
        check("coll_first_addr", 32'(firstAddr), 32'h0020);
        check("coll_second_addr", 32'(secondAddr), 32'h0080);
        check("coll_disp_edges", 32'(dvC - c), 32'd3);
        check("coll_cpu_ack_edges", 32'(ackC - (c + 1)), 32'd3);
        repeat (3) @(negedge iClk25);

        // Starvation: continuous display stream with a CPU write waiting
        c = cyc;
        cpuStart(1'b1, 14'h3000, 8'hA5, 1'b1);
        dispDrive(13'd0);
        ackC = -1;
        weC = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge iClk25);
            if (oRamWe && weC == -1) weC = cyc;
            if (oCpuAck && ackC == -1) begin
                ackC = cyc;
                iCpuReq = 1'b0;
            end
            if (k < 16) dispDrive(13'(k));
            else iDispReq = 1'b0;
        end
        check("starve_cpu_issue_edge", 32'(weC - c), 32'd5);
`ifdef VRAM_ARB_POSTWR_EN
        check("starve_cpu_ack_edge", 32'(ackC - c), 32'd1);
`else
        check("starve_cpu_ack_edge", 32'(ackC - c), 32'd5);
`endif
        repeat (3) @(negedge iClk25);

        // Reset pulse one edge after a CPU read issues
        cpuStart(1'b0, 14'h0021, 8'h00, 1'b0);
        @(negedge iClk25);
        iRstN = 1'b0;
        iCpuReq = 1'b0;
        #1;
        check("rst_pulse_disp_cpu", 32'({oDispValid, oDispData, oCpuAck, oCpuRdData}), 32'd0);
        check("rst_pulse_ram", 32'({oRamAddr, oRamWe, oRamBe, oRamWrData}), 32'd0);
        @(negedge iClk25);
        iRstN = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge iClk25);
            if (oCpuAck) cnt++;
        end
        check("rst_pulse_no_ack", 32'(cnt), 32'd0);
        c = cyc;
        cpuStart(1'b0, 14'h0021, 8'h00, 1'b1);
        waitAck("cpu_ack_within_bound", ackC);
        check("rst_then_rd_latency", 32'(ackC - c), 32'd3);
        repeat (3) @(negedge iClk25);

`ifdef VRAM_ARB_POSTWR_EN
        // Two back-to-back posted writes under a continuous display stream
        c = cyc;
        cpuStart(1'b1, 14'h2002, 8'h11, 1'b1);
        dispDrive(13'h0100);
        a1 = -1;
        a2 = -1;
        dr = -1;
        for (int k = 1; k <= 60 && !(a2 != -1 && k > 16); k++) begin
            @(negedge iClk25);
            if (oRamWe && dr == -1) dr = cyc;
            if (oCpuAck) begin
                if (a1 == -1) begin
                    a1 = cyc;
                    cpuStart(1'b1, 14'h2003, 8'h22, 1'b1);
                end else if (a2 == -1) begin
                    a2 = cyc;
                    iCpuReq = 1'b0;
                end
            end
            if (k < 16) dispDrive(13'h0100 + 13'(k));
            else iDispReq = 1'b0;
        end
        iDispReq = 1'b0;
        check("postwr_first_ack_edge", 32'(a1 - c), 32'd1);
        check("postwr_first_drain_edge", 32'(dr - c), 32'd5);
        check("postwr_second_after_drain", 32'((a2 != -1) && (a2 > dr)), 32'd1);
        @(negedge iClk25);
        cpuStart(1'b0, 14'h2002, 8'h00, 1'b1);
        waitAck("cpu_ack_within_bound", ackC);
        @(negedge iClk25);
        cpuStart(1'b0, 14'h2003, 8'h00, 1'b1);
        waitAck("cpu_ack_within_bound", ackC);
        repeat (3) @(negedge iClk25);
`endif

        // Random mixed traffic: display in the low half, CPU writes in the high half
        fork
            begin : dispGen
                logic [12:0] da;
                for (int k = 0; k < 600; k++) begin
                    @(negedge iClk25);
                    if ($urandom_range(99, 0) < 40) begin
                        da = 13'($urandom_range(4095, 0));
                        dispDrive(da);
                    end else begin
                        iDispReq = 1'b0;
                    end
                end
                @(negedge iClk25);
                iDispReq = 1'b0;
            end
            begin : cpuGen
                logic [13:0] ca;
                int rc;
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(3, 0)) @(negedge iClk25);
                    @(negedge iClk25);
                    if ($urandom_range(1, 0) == 1) begin
                        ca = 14'h2000 | 14'($urandom_range(8191, 0));
                        cpuStart(1'b1, ca, 8'($urandom), 1'b1);
                    end else begin
                        ca = 14'($urandom_range(16383, 0));
                        cpuStart(1'b0, ca, 8'h00, 1'b1);
                    end
                    waitAck("cpu_ack_within_bound", rc);
                end
            end
        join

        repeat (12) @(negedge iClk25);
        check("disp_queue_drained", 32'(dispQ.size()), 32'd0);
        check("cpu_queue_drained", 32'(cpuQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
